// File: rtl/bit_population_pkg.sv
// Shared types and constants for the bit population generator.
// Holds the FSM state encoding, the count-port width helper and the
// 16-bit Galois LFSR constants and step function.
package bit_population_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          LFSR_W    = 16;
    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Width of a port that carries a population count of 0..width
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

    // One Galois step: shift right, fold taps in when the bit leaving is 1
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
        logic [LFSR_W-1:0] nxt;
        if (cur[0]) begin
            nxt = (cur >> 1) ^ LFSR_TAPS;
        end else begin
            nxt = cur >> 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bit_population_generator_lfsr.sv
// Free-running 16-bit Galois LFSR used to scatter bit positions.
// A zero seed would lock the register, so it is replaced by 16'h0001.
module bpg_lfsr
    import bit_population_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    output logic [LFSR_W-1:0] lfsr_o
);

    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [LFSR_W-1:0] lfsr_r;

    // Advance every cycle regardless of what the generator FSM is doing
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            lfsr_r <= SEED_EFF;
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    assign lfsr_o = lfsr_r;

endmodule

// File: rtl/bit_population_generator.sv
// Bit population generator: accepts a count N and emits one WIDTH-bit word
// with exactly N bits set, one bit per FILL cycle. Positions walk from an
// LFSR-chosen start with an odd LFSR-chosen stride, which never repeats a
// position within WIDTH steps because WIDTH is a power of two.
// Optional build macro BIT_POP_GEN_THERMO_EN: start at bit 0 with stride 1,
// giving a thermometer code with identical timing.
module bit_population_generator
    import bit_population_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic                      clk_i,
    input  logic                      arst_n_i,
    input  logic [cnt_w(WIDTH)-1:0]   cnt_i,
    input  logic                      cnt_val_i,
    output logic                      cnt_rdy_o,
    output logic [WIDTH-1:0]          data_o,
    output logic                      data_val_o,
    input  logic                      data_rdy_i
);

    localparam int             L       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int             CW      = cnt_w(WIDTH);
    localparam logic [CW-1:0]  WIDTH_C = CW'(WIDTH);

    if ((WIDTH < 2) || ((WIDTH & (WIDTH - 1)) != 0) || (2 * L > LFSR_W)) begin : g_bad_width
        $error("bit_population_generator: WIDTH must be a power of two between 2 and 256");
    end

    logic [LFSR_W-1:0] lfsr_s;
    logic [CW-1:0]     n_sat_s;
    logic [L-1:0]      ptr_init_s;
    logic [L-1:0]      stride_init_s;
    logic [WIDTH-1:0]  bit_mask_s;

    state_t            state_r;
    logic [WIDTH-1:0]  word_r;
    logic [L-1:0]      ptr_r;
    logic [L-1:0]      stride_r;
    logic [CW-1:0]     rem_r;
    logic [WIDTH-1:0]  data_r;
    logic              data_val_r;
    logic              cnt_rdy_r;

    bpg_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .lfsr_o   (lfsr_s)
    );

    // Saturate the request, pick start/stride, and decode the current bit
    always_comb begin
        if (cnt_i > WIDTH_C) begin
            n_sat_s = WIDTH_C;
        end else begin
            n_sat_s = cnt_i;
        end
`ifdef BIT_POP_GEN_THERMO_EN
        ptr_init_s    = '0;
        stride_init_s = L'(1'b1);
`else
        ptr_init_s    = lfsr_s[L-1:0];
        // Forcing bit 0 keeps the stride odd, hence coprime with WIDTH
        stride_init_s = lfsr_s[2*L-1:L] | L'(1'b1);
`endif
        bit_mask_s = WIDTH'(1'b1) << ptr_r;
    end

    // Keep LFSR bits that do not steer placement from tripping unused checks
    logic unused_lfsr_s;
    assign unused_lfsr_s = ^lfsr_s;

    // Generator FSM with registered handshake and data outputs
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_r    <= IDLE;
            word_r     <= '0;
            ptr_r      <= '0;
            stride_r   <= L'(1'b1);
            rem_r      <= '0;
            data_r     <= '0;
            data_val_r <= 1'b0;
            cnt_rdy_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cnt_val_i && cnt_rdy_r) begin
                        word_r    <= '0;
                        ptr_r     <= ptr_init_s;
                        stride_r  <= stride_init_s;
                        rem_r     <= n_sat_s;
                        cnt_rdy_r <= 1'b0;
                        if (n_sat_s == '0) begin
                            // Empty word goes straight out next cycle
                            state_r    <= DONE;
                            data_r     <= '0;
                            data_val_r <= 1'b1;
                        end else begin
                            state_r <= FILL;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FILL: begin
                    word_r <= word_r | bit_mask_s;
                    ptr_r  <= ptr_r + stride_r;
                    rem_r  <= rem_r - CW'(1'b1);
                    if (rem_r == CW'(1'b1)) begin
                        // Publish the finished word as DONE is entered
                        state_r    <= DONE;
                        data_r     <= word_r | bit_mask_s;
                        data_val_r <= 1'b1;
                    end else begin
                        state_r <= FILL;
                    end
                end
                DONE: begin
                    if (data_rdy_i) begin
                        state_r    <= IDLE;
                        data_val_r <= 1'b0;
                        cnt_rdy_r  <= 1'b1;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    data_val_r <= 1'b0;
                    cnt_rdy_r  <= 1'b1;
                end
            endcase
        end
    end

    assign cnt_rdy_o  = cnt_rdy_r;
    assign data_o     = data_r;
    assign data_val_o = data_val_r;

endmodule

// File: tb/tb_bit_population_generator.sv
// Scoreboard bench for bit_population_generator (WIDTH=8).
// The driver predicts each word from the placement rules and a reference
// LFSR, pushes it with its due cycle; a monitor pops on every handshake.
module tb_bit_population_generator;

    localparam int          WIDTH = 8;
    localparam int          CW    = 4;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic             clk = 1'b0;
    logic             arst_n = 1'b0;
    logic [CW-1:0]    cnt = '0;
    logic             cnt_val = 1'b0;
    logic             cnt_rdy;
    logic [WIDTH-1:0] data;
    logic             data_val;
    logic             data_rdy = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issued = 0;
    bit mon_en = 1'b0;
    logic [15:0] m_lfsr = SEED;

    typedef struct {
        logic [WIDTH-1:0] word;
        int               n;
        int               due;
    } exp_t;
    exp_t q[$];

    bit_population_generator #(.WIDTH(WIDTH), .SEED(SEED)) dut (
        .clk_i      (clk),
        .arst_n_i   (arst_n),
        .cnt_i      (cnt),
        .cnt_val_i  (cnt_val),
        .cnt_rdy_o  (cnt_rdy),
        .data_o     (data),
        .data_val_o (data_val),
        .data_rdy_i (data_rdy)
    );

    always #5 clk = ~clk;

    // Cycle index, constant between rising edges
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference LFSR: polynomial x^16+x^14+x^13+x^11+1, right-shift Galois form
    function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
        logic [15:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // Expected word: n positions start, start+stride, ... modulo WIDTH
    function automatic logic [WIDTH-1:0] model_word(input int n, input logic [15:0] lf);
        int ptr;
        int stride;
        logic [WIDTH-1:0] w;
        w = '0;
`ifdef BIT_POP_GEN_THERMO_EN
        ptr = 0;
        stride = 1;
`else
        ptr = int'(lf) % WIDTH;
        stride = ((int'(lf) / WIDTH) % WIDTH) | 1;
`endif
        for (int k = 0; k < n; k++) w[(ptr + k * stride) % WIDTH] = 1'b1;
        return w;
    endfunction

    // One clock of stimulus, driven at the falling edge
    task automatic step(input bit val, input int c, input bit rdy);
        int n;
        @(negedge clk);
        m_lfsr = ref_lfsr(m_lfsr);
        cnt_val = val;
        cnt = c[CW-1:0];
        data_rdy = rdy;
        check("cnt_rdy", {31'd0, cnt_rdy}, {31'd0, q.size() == 0});
        if (val && q.size() == 0) begin
            n = (c > WIDTH) ? WIDTH : c;
            q.push_back('{model_word(n, m_lfsr), n, cyc + 1 + n});
            issued++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) step(1'b0, 0, 1'b1);
        check("drain_timeout", q.size(), 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        m_lfsr = SEED;
        mon_en = 1'b1;
    endtask

    // Monitor: compare every presented word against the scoreboard head
    initial begin : monitor
        bit in_hold;
        exp_t e;
        in_hold = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!mon_en) begin
                in_hold = 1'b0;
            end else if (data_val === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h expected=none at cycle %0d", data, cyc);
                end else begin
                    e = q[0];
                    if (!in_hold) check("latency", cyc, e.due);
                    check("data", data, e.word);
                    check("popcount", $countones(data), e.n);
                    if (data_rdy) begin
                        void'(q.pop_front());
                        in_hold = 1'b0;
                    end else begin
                        in_hold = 1'b1;
                    end
                end
            end else begin
                if (in_hold) check("valid_dropped", {31'd0, data_val}, 32'd1);
                in_hold = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        // Reset state
        @(negedge clk);
        #1;
        check("rst_val", {31'd0, data_val}, 32'd0);
        check("rst_rdy", {31'd0, cnt_rdy}, 32'd1);
        check("rst_data", {24'd0, data}, 32'd0);
        release_reset();

        // Loopback sweep including saturation (0..15)
        for (int c = 0; c < 16; c++) begin
            step(1'b1, c, 1'b1);
            drain();
        end

        // Backpressure: stall 20 cycles in DONE while offering new counts
        step(1'b1, 5, 1'b0);
        for (int i = 0; i < 26; i++) step(1'b1, int'($urandom_range(0, 8)), 1'b0);
        check("bp_valid", {31'd0, data_val}, 32'd1);
        drain();

        // Reset mid-FILL, then a normal request
        step(1'b1, 6, 1'b1);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        #2;
        mon_en = 1'b0;
        arst_n = 1'b0;
        #1;
        check("midrst_val", {31'd0, data_val}, 32'd0);
        check("midrst_rdy", {31'd0, cnt_rdy}, 32'd1);
        check("midrst_data", {24'd0, data}, 32'd0);
        q.delete();
        release_reset();
        step(1'b1, 6, 1'b1);
        drain();

        // Randomized traffic with downstream stalls
        issued = 0;
        for (int i = 0; i < 40000 && issued < 1000; i++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 8)), $urandom_range(0, 3) != 0);
        end
        check("random_issued", issued, 1000);
        drain();
        check("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
